// File: rtl/bit_insertion_8x16_seq_if.sv
// Handshake bundle between a narrow field producer, the bit-insertion block and a 16-bit link.
// Optional o_collision member exists only when COLLISION_DETECT_EN is defined.
interface bit_insertion_8x16_seq_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int IN_DATA_WIDTH = DATA_WIDTH >> 1,
  parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1
);
  logic                     i_valid;
  logic [IN_DATA_WIDTH-1:0] i_data_bus;
  logic [COMMAND_WIDTH-1:0] i_cmd;
  logic                     i_last;
  logic                     i_en;
  logic                     o_ready;
  logic                     o_valid;
  logic [DATA_WIDTH-1:0]    o_data_bus;
  logic                     i_ready;
`ifdef COLLISION_DETECT_EN
  logic                     o_collision;

  modport master (
    output i_valid, i_data_bus, i_cmd, i_last, i_en, i_ready,
    input  o_ready, o_valid, o_data_bus, o_collision
  );

  modport slave (
    input  i_valid, i_data_bus, i_cmd, i_last, i_en, i_ready,
    output o_ready, o_valid, o_data_bus, o_collision
  );
`else
  modport master (
    output i_valid, i_data_bus, i_cmd, i_last, i_en, i_ready,
    input  o_ready, o_valid, o_data_bus
  );

  modport slave (
    input  i_valid, i_data_bus, i_cmd, i_last, i_en, i_ready,
    output o_ready, o_valid, o_data_bus
  );
`endif
endinterface

// File: rtl/bit_insertion_8x16_seq.sv
// Inserts 8-bit fields at bit offset i_cmd into a 16-bit word, emits on i_last (COLLISION_DETECT_EN adds o_collision).
// Latency: last beat accepted at edge N -> o_valid at N+1.
// Backpressure: o_ready drops while a word waits for i_ready; a draining word frees the slot the same cycle.
module bit_insertion_8x16_seq #(
  parameter int DATA_WIDTH    = 16,
  parameter int IN_DATA_WIDTH = DATA_WIDTH >> 1,
  parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  bit_insertion_8x16_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] FIELD_MASK =
    {{(DATA_WIDTH-IN_DATA_WIDTH){1'b0}}, {IN_DATA_WIDTH{1'b1}}};

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] acc, acc_nxt;
  logic [DATA_WIDTH-1:0] wmask, wmask_nxt;
  logic [DATA_WIDTH-1:0] out_dat, out_dat_nxt;
  logic                  out_vld, out_vld_nxt;

  logic                  ready;
  logic                  acc_in;
  logic                  out_fire;
  logic [DATA_WIDTH-1:0] field_mask;
  logic [DATA_WIDTH-1:0] field_dat;
  logic [DATA_WIDTH-1:0] base_dat;
  logic [DATA_WIDTH-1:0] base_mask;
  logic [DATA_WIDTH-1:0] merged;

  assign ready    = ~rst & bus.i_en & ((state != HOLD) | bus.i_ready);
  assign acc_in   = bus.i_valid & bus.i_en & ready;
  assign out_fire = out_vld & bus.i_ready & bus.i_en;

  // A new word (IDLE, or HOLD where acc is already clear) merges onto zero.
  assign field_mask = FIELD_MASK << bus.i_cmd;
  assign field_dat  = {{(DATA_WIDTH-IN_DATA_WIDTH){1'b0}}, bus.i_data_bus} << bus.i_cmd;
  assign base_dat   = (state == ACCUM) ? acc   : '0;
  assign base_mask  = (state == ACCUM) ? wmask : '0;
  assign merged     = (base_dat & ~field_mask) | field_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      wmask   <= '0;
      out_dat <= '0;
      out_vld <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      wmask   <= wmask_nxt;
      out_dat <= out_dat_nxt;
      out_vld <= out_vld_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    wmask_nxt   = wmask;
    out_dat_nxt = out_dat;
    out_vld_nxt = out_vld;

    if (out_fire) begin
      state_nxt   = IDLE;
      out_dat_nxt = '0;
      out_vld_nxt = 1'b0;
    end

    // Acceptance in HOLD implies out_fire, so a last beat here replaces the drained word with no bubble.
    if (acc_in) begin
      if (bus.i_last) begin
        state_nxt   = HOLD;
        out_dat_nxt = merged;
        out_vld_nxt = 1'b1;
        acc_nxt     = '0;
        wmask_nxt   = '0;
      end else begin
        state_nxt   = ACCUM;
        acc_nxt     = merged;
        wmask_nxt   = base_mask | field_mask;
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = out_vld;
  assign bus.o_data_bus = out_dat;

`ifdef COLLISION_DETECT_EN
  logic coll_q;
  logic coll_hit;

  assign coll_hit = acc_in & (|(base_mask & field_mask));

  // Frozen with everything else while i_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= 1'b0;
    end else if (bus.i_en) begin
      coll_q <= coll_hit;
    end
  end

  assign bus.o_collision = coll_q;
`endif

endmodule

// File: tb/tb_bit_insertion_8x16_seq.sv
// Directed plus randomized stimulus; a bit-level reference model pushes expected words into a scoreboard.
module tb_bit_insertion_8x16_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bit_insertion_8x16_seq_if bus ();

  bit_insertion_8x16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Reference model: partial word, per-bit written flags, queue of words awaiting drain.
  logic [15:0] part;
  logic [15:0] wr;
  logic [15:0] sb[$];
  logic [15:0] dlog[$];
  bit          seen_rst = 0;
  bit          exp_coll = 0;
  bit          exp_vld, exp_rdy, fire, acc, ovl;

  always @(negedge clk) begin
    if (rst) begin
      chk("o_ready_in_reset", 32'(bus.o_ready), 32'd0);
      sb.delete();
      part     = '0;
      wr       = '0;
      exp_coll = 0;
      seen_rst = 1;
    end else if (seen_rst) begin
      exp_vld = (sb.size() != 0);
      chk("o_valid", 32'(bus.o_valid), 32'(exp_vld));
      if (exp_vld) chk("o_data_bus", 32'(bus.o_data_bus), 32'(sb[0]));
      else         chk("o_data_bus_idle", 32'(bus.o_data_bus), 32'd0);
`ifdef COLLISION_DETECT_EN
      chk("o_collision", 32'(bus.o_collision), 32'(exp_coll));
`endif
      exp_rdy = bus.i_en && (!exp_vld || bus.i_ready);
      chk("o_ready", 32'(bus.o_ready), 32'(exp_rdy));
      fire = exp_vld && bus.i_ready && bus.i_en;
      acc  = bus.i_valid && bus.i_en && exp_rdy;
      if (fire) dlog.push_back(sb.pop_front());
      if (bus.i_en) exp_coll = 0;
      if (acc) begin
        ovl = 0;
        for (int b = 0; b < 8; b++) begin
          int idx;
          idx = int'(bus.i_cmd) + b;
          if (wr[idx]) ovl = 1;
          part[idx] = bus.i_data_bus[b];
          wr[idx]   = 1'b1;
        end
        exp_coll = ovl;
        if (bus.i_last) begin
          sb.push_back(part);
          part = '0;
          wr   = '0;
        end
      end
    end
  end

  // Randomized i_ready / i_en when enabled.
  bit rnd = 0;
  always begin
    @(posedge clk);
    #1;
    if (rnd) begin
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_en    = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] c, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    bus.i_valid    = 1'b1;
    bus.i_data_bus = d;
    bus.i_cmd      = c;
    bus.i_last     = l;
    while (!done) begin
      @(negedge clk);
      if (bus.o_ready && bus.i_en) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n >= 300) begin
        chk("send_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int target);
    int n;
    n = 0;
    while (dlog.size() < target && n < 300) begin
      step(1);
      n++;
    end
    chk("drain_timeout", 32'(dlog.size() >= target), 32'd1);
  endtask

  task automatic chk_log(input string name, input int back, input logic [15:0] exp);
    int i;
    i = dlog.size() - 1 - back;
    if (i < 0) chk(name, 32'hFFFF_FFFF, 32'(exp));
    else       chk(name, 32'(dlog[i]), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.i_valid    = 1'b0;
    bus.i_data_bus = '0;
    bus.i_cmd      = '0;
    bus.i_last     = 1'b0;
    bus.i_en       = 1'b1;
    bus.i_ready    = 1'b1;
    rst            = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    // Single beat
    n0 = dlog.size();
    send(8'hA5, 3'd0, 1'b1);
    wait_drain(n0 + 1);
    chk_log("single_beat", 0, 16'h00A5);

    // Two beats
    n0 = dlog.size();
    send(8'h42, 3'd0, 1'b0);
    send(8'hA4, 3'd7, 1'b1);
    wait_drain(n0 + 1);
    chk_log("two_beats", 0, 16'h5242);

    // Overlap
    n0 = dlog.size();
    send(8'hFF, 3'd0, 1'b0);
    send(8'h00, 3'd4, 1'b1);
    wait_drain(n0 + 1);
    chk_log("overlap", 0, 16'h000F);

    // Backpressure with a new last beat offered while holding
    n0 = dlog.size();
    bus.i_ready = 1'b0;
    send(8'hA5, 3'd0, 1'b1);
    fork
      send(8'h11, 3'd1, 1'b1);
      begin
        step(3);
        bus.i_ready = 1'b1;
      end
    join
    wait_drain(n0 + 2);
    chk_log("bp_first", 1, 16'h00A5);
    chk_log("bp_second", 0, 16'h0022);

    // Enable low in ACCUM and in HOLD
    n0 = dlog.size();
    send(8'h42, 3'd0, 1'b0);
    bus.i_en = 1'b0;
    step(2);
    bus.i_en = 1'b1;
    bus.i_ready = 1'b0;
    send(8'hA4, 3'd7, 1'b1);
    bus.i_en = 1'b0;
    bus.i_ready = 1'b1;
    step(2);
    chk("en_hold_no_drain", 32'(dlog.size()), 32'(n0));
    bus.i_en = 1'b1;
    wait_drain(n0 + 1);
    chk_log("en_resume", 0, 16'h5242);

    // Reset mid-word, then a clean word
    send(8'h42, 3'd0, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n0 = dlog.size();
    send(8'h01, 3'd3, 1'b1);
    wait_drain(n0 + 1);
    chk_log("after_reset", 0, 16'h0008);

    // Reset while a word is held
    bus.i_ready = 1'b0;
    send(8'h77, 3'd2, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    step(2);

    // Randomized traffic
    rnd = 1;
    repeat (300) begin
      send(8'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end
    rnd = 0;
    step(1);
    bus.i_ready = 1'b1;
    bus.i_en    = 1'b1;
    send(8'h00, 3'd0, 1'b1);
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
        step(1);
        n++;
      end
      chk("final_drain", 32'(sb.size()), 32'd0);
    end
    step(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
